// File: rtl/seg7_trace_display_if.sv
// Trace bus carrying the CPU's fetch indicator and the values to be snapshotted.
// The CPU side drives it (master); the display stage observes it (slave).
interface seg7_trace_display_if;
   logic        instr_change;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] addr;

   modport master (output instr_change, inst, pc, addr);
   modport slave  (input  instr_change, inst, pc, addr);
endinterface

// File: rtl/seg7_trace_display.sv
// Debug display stage: snapshots pc/inst/addr on each new instruction, counts fetches,
// and scans one selected 32-bit value as 8 hex digits onto an active-low 7-segment display.
module seg7_trace_display #(
   parameter logic [19:0] SCAN_DIV = 20'd50000
) (
   input  logic                       clk,
   input  logic                       rst,
   seg7_trace_display_if.slave        trace,
   input  logic [1:0]                 sel_mode,
   input  logic                       freeze,
   output logic [7:0]                 o_seg,
   output logic [7:0]                 o_sel,
   output logic [31:0]                instr_cnt
);

   logic        chg_d_reg;
   logic [31:0] cnt_reg, cnt_next;
   logic [31:0] pc_s_reg, pc_s_next;
   logic [31:0] inst_s_reg, inst_s_next;
   logic [31:0] addr_s_reg, addr_s_next;
   logic [19:0] pre_reg, pre_next;
   logic [2:0]  idx_reg, idx_next;
   logic [7:0]  seg_reg, seg_next;
   logic [7:0]  sel_reg;
   logic [7:0]  sel_dec;
   logic        fire;
   logic [31:0] disp_val;
   logic [31:0] disp_shift;
   logic [3:0]  nibble;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // One-cold digit enable: only the digit currently being scanned is driven low.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_sel
         assign sel_dec[gi] = (idx_reg != gi[2:0]);
      end
   endgenerate

   always_comb begin
      fire        = trace.instr_change & ~chg_d_reg;
      cnt_next    = cnt_reg;
      pc_s_next   = pc_s_reg;
      inst_s_next = inst_s_reg;
      addr_s_next = addr_s_reg;
      if (fire) begin
         cnt_next = cnt_reg + 32'd1;
         if (!freeze) begin
            pc_s_next   = trace.pc;
            inst_s_next = trace.inst;
            addr_s_next = trace.addr;
         end
      end

      pre_next = pre_reg + 20'd1;
      idx_next = idx_reg;
      if (pre_reg == SCAN_DIV - 20'd1) begin
         pre_next = 20'd0;
         idx_next = idx_reg + 3'd1;
      end

      case (sel_mode)
         2'b00:   disp_val = pc_s_reg;
         2'b01:   disp_val = inst_s_reg;
         2'b10:   disp_val = addr_s_reg;
         default: disp_val = cnt_reg;
      endcase
      disp_shift = disp_val >> {idx_reg, 2'b00};
      nibble     = disp_shift[3:0];

      // Decimal point on the leftmost digit flags that snapshots are frozen.
      seg_next = {~(freeze & (idx_reg == 3'd7)), ~hex7(nibble)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_d_reg  <= 1'b0;
         cnt_reg    <= 32'd0;
         pc_s_reg   <= 32'd0;
         inst_s_reg <= 32'd0;
         addr_s_reg <= 32'd0;
         pre_reg    <= 20'd0;
         idx_reg    <= 3'd0;
         seg_reg    <= 8'hFF;
         sel_reg    <= 8'hFF;
      end else begin
         chg_d_reg  <= trace.instr_change;
         cnt_reg    <= cnt_next;
         pc_s_reg   <= pc_s_next;
         inst_s_reg <= inst_s_next;
         addr_s_reg <= addr_s_next;
         pre_reg    <= pre_next;
         idx_reg    <= idx_next;
         seg_reg    <= seg_next;
         sel_reg    <= sel_dec;
      end
   end

   assign o_seg     = seg_reg;
   assign o_sel     = sel_reg;
   assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_seg7_trace_display.sv
// Bench for seg7_trace_display: table vectors, hand sequences and random stimulus,
// all checked cycle by cycle against a time-based behavioural model of the display.
module tb_seg7_trace_display;

   localparam int SCAN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel_mode;
   logic        freeze;
   logic [7:0]  o_seg;
   logic [7:0]  o_sel;
   logic [31:0] instr_cnt;

   seg7_trace_display_if tr ();

   seg7_trace_display #(.SCAN_DIV(20'd4)) dut (
      .clk       (clk),
      .rst       (rst),
      .trace     (tr),
      .sel_mode  (sel_mode),
      .freeze    (freeze),
      .o_seg     (o_seg),
      .o_sel     (o_sel),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [6:0] hex_tab [16];

   // Model state: snapshots, count, last instr_change level, edges since reset release.
   logic        m_chg_d;
   logic [31:0] m_cnt, m_pc, m_inst, m_addr;
   int          m_k;
   logic [7:0]  exp_seg, exp_sel;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] addr;
      logic [1:0]  sel;
      logic        frz;
      logic        pulse;
      logic [31:0] exp_cnt;
      logic [31:0] exp_v;
   } vec_t;

   vec_t vt [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_chg_d = 1'b0;
      m_cnt   = 32'd0;
      m_pc    = 32'd0;
      m_inst  = 32'd0;
      m_addr  = 32'd0;
      m_k     = 0;
      exp_seg = 8'hFF;
      exp_sel = 8'hFF;
   endtask

   // Advance one clock: update the model at the rising edge, compare on the falling edge.
   task automatic tick();
      int          d;
      logic [31:0] v;
      logic        fire;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         d = (m_k / SCAN) % 8;
         case (sel_mode)
            2'd0: v = m_pc;
            2'd1: v = m_inst;
            2'd2: v = m_addr;
            default: v = m_cnt;
         endcase
         exp_sel = 8'hFF;
         exp_sel[d] = 1'b0;
         exp_seg = {~(freeze && d == 7), ~hex_tab[v[4*d +: 4]]};
         fire = tr.instr_change && !m_chg_d;
         m_chg_d = tr.instr_change;
         if (fire) begin
            m_cnt = m_cnt + 32'd1;
            if (!freeze) begin
               m_pc = tr.pc; m_inst = tr.inst; m_addr = tr.addr;
            end
         end
         m_k++;
      end
      @(negedge clk);
      check("o_sel", {24'd0, o_sel}, {24'd0, exp_sel});
      check("o_seg", {24'd0, o_seg}, {24'd0, exp_seg});
      check("instr_cnt", instr_cnt, m_cnt);
   endtask

   // Watch a full 8-digit scan and reassemble the displayed value from the segments.
   task automatic scan_value(output logic [31:0] obs);
      obs = 32'd0;
      repeat (8 * SCAN) begin
         tick();
         for (int i = 0; i < 8; i++) begin
            if (!o_sel[i]) begin
               for (int n = 0; n < 16; n++)
                  if (o_seg[6:0] == ~hex_tab[n]) obs[4*i +: 4] = n[3:0];
            end
         end
      end
   endtask

   task automatic pulse();
      tr.instr_change = 1'b1;
      tick();
      tr.instr_change = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] obs, base;
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      vt[0] = '{32'h0040_0004, 32'h2408_0005, 32'h1000_0000, 2'd0, 1'b0, 1'b1, 32'd1, 32'h0040_0004};
      vt[1] = '{32'h0040_0004, 32'h2408_0005, 32'h1000_0000, 2'd1, 1'b0, 1'b0, 32'd1, 32'h2408_0005};
      vt[2] = '{32'h0040_0004, 32'h2408_0005, 32'h1000_0000, 2'd2, 1'b0, 1'b0, 32'd1, 32'h1000_0000};
      vt[3] = '{32'h0040_0008, 32'hDEAD_BEEF, 32'h1000_0010, 2'd0, 1'b1, 1'b1, 32'd2, 32'h0040_0004};
      vt[4] = '{32'h0040_0008, 32'hDEAD_BEEF, 32'h1000_0010, 2'd0, 1'b0, 1'b1, 32'd3, 32'h0040_0008};
      vt[5] = '{32'h0040_0008, 32'hDEAD_BEEF, 32'h1000_0010, 2'd3, 1'b0, 1'b0, 32'd3, 32'h0000_0003};

      rst = 1'b1; sel_mode = 2'd0; freeze = 1'b0;
      tr.instr_change = 1'b0; tr.pc = '0; tr.inst = '0; tr.addr = '0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("release_sel", {24'd0, o_sel}, 32'hFE);
      check("release_seg", {24'd0, o_seg}, 32'hC0);

      foreach (vt[i]) begin
         tr.pc = vt[i].pc; tr.inst = vt[i].inst; tr.addr = vt[i].addr;
         sel_mode = vt[i].sel; freeze = vt[i].frz;
         if (vt[i].pulse) pulse(); else tick();
         scan_value(obs);
         check($sformatf("vec%0d_cnt", i), instr_cnt, vt[i].exp_cnt);
         check($sformatf("vec%0d_value", i), obs, vt[i].exp_v);
      end

      // Level held high counts once; two separated pulses count twice.
      freeze = 1'b0; sel_mode = 2'd3;
      base = m_cnt;
      tr.instr_change = 1'b1;
      repeat (10) tick();
      tr.instr_change = 1'b0;
      tick();
      check("held_level", instr_cnt, base + 32'd1);
      tr.instr_change = 1'b1; tick(); tr.instr_change = 1'b0; tick(); tick();
      tr.instr_change = 1'b1; tick(); tr.instr_change = 1'b0; tick();
      check("two_pulses", instr_cnt, base + 32'd3);

      for (int c = 0; c < 400; c++) begin
         tr.instr_change = ($urandom_range(0, 2) == 0);
         freeze   = ($urandom_range(0, 3) == 0);
         sel_mode = 2'($urandom_range(0, 3));
         tr.pc = $urandom; tr.inst = $urandom; tr.addr = $urandom;
         tick();
      end

      // Count wrap from all-ones.
      tr.instr_change = 1'b0; freeze = 1'b0; tick();
      force dut.cnt_reg = 32'hFFFF_FFFF;
      #1 release dut.cnt_reg;
      m_cnt = 32'hFFFF_FFFF;
      pulse();
      check("wrap_cnt", instr_cnt, 32'd0);
      sel_mode = 2'd3;
      tick();
      scan_value(obs);
      check("wrap_display", obs, 32'd0);

      // Asynchronous reset at idx=5, prescaler=2, between clock edges.
      while (m_k % (8 * SCAN) != 5 * SCAN + 2) tick();
      #2 rst = 1'b1;
      #1;
      check("async_sel", {24'd0, o_sel}, 32'hFF);
      check("async_seg", {24'd0, o_seg}, 32'hFF);
      check("async_cnt", instr_cnt, 32'd0);
      model_reset();
      tick();
      rst = 1'b0;
      tick();
      check("rerelease_sel", {24'd0, o_sel}, 32'hFE);
      check("rerelease_seg", {24'd0, o_seg}, 32'hC0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
